// File: rtl/outport_fifo_pkg.sv
// Shared sizing constants for the output-port FIFO and its storage.
// No logic, so no latency.
// No flow control lives here.
package outport_fifo_pkg;

  localparam int OUTPORT_DEPTH = 4;
  localparam int OUTPORT_PTR_W = 2;
  localparam int OUTPORT_CNT_W = 3;
  localparam int WORD_W        = 32;

endpackage

// File: rtl/fifo_mem_4x32.sv
// 4x32 register-file storage for the output-port FIFO.
// Write lands on the rising clk edge; the read port is combinational (0 cycles).
// No flow control: the parent decides when a write is allowed.
module fifo_mem_4x32
  import outport_fifo_pkg::*;
(
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [OUTPORT_PTR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0]        i_wdata,
  input  logic [OUTPORT_PTR_W-1:0] i_raddr,
  output logic [WORD_W-1:0]        o_rdata
);

  logic [WORD_W-1:0] r_mem [OUTPORT_DEPTH];

  // Storage write. There is no reset: contents are only meaningful once
  // count says a slot is occupied.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/outport_fifo.sv
// 4-deep output-port FIFO between the datapath bus and an external device, with display latch.
// Push to dev_valid is 1 cycle; dev_data is the combinational head of storage.
// A full FIFO drops pushes (sticky overflow) unless a pop frees a slot that same cycle; stall = full && !dev_ready.
module outport_fifo
  import outport_fifo_pkg::*;
(
  input  logic                     clk,
  input  logic                     clr,
  input  logic [WORD_W-1:0]        bus_data,
  input  logic                     outport_enable,
  input  logic                     ovf_clr,
  input  logic                     dev_ready,
  output logic [WORD_W-1:0]        dev_data,
  output logic                     dev_valid,
  output logic [WORD_W-1:0]        out_port_q,
  output logic [OUTPORT_CNT_W-1:0] count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     stall
);

  logic [OUTPORT_PTR_W-1:0] r_wr_ptr;
  logic [OUTPORT_PTR_W-1:0] r_rd_ptr;
  logic [OUTPORT_CNT_W-1:0] r_count;
  logic                     r_overflow;
  logic [WORD_W-1:0]        r_out_q;

  logic        w_push;
  logic        w_pop;
  logic        w_ovf_event;
  logic [WORD_W-1:0] w_rdata;

  // Flags come straight from the registered count.
  assign full      = (r_count == OUTPORT_CNT_W'(OUTPORT_DEPTH));
  assign empty     = (r_count == '0);
  assign dev_valid = !empty;
  assign dev_data  = w_rdata;

  // A pop can only happen with a valid head, so an empty FIFO never pops.
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop       = dev_valid && dev_ready;
  assign w_push      = outport_enable && (!full || w_pop);
  assign w_ovf_event = outport_enable && full && !w_pop;

  assign stall = full && !dev_ready;

  fifo_mem_4x32 u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointer and occupancy tracking; pointers wrap naturally at 2 bits.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a fresh drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_event) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // Latch the word the device just took, for display.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_out_q <= '0;
    end else if (w_pop) begin
      r_out_q <= w_rdata;
    end
  end

  assign count      = r_count;
  assign overflow   = r_overflow;
  assign out_port_q = r_out_q;

endmodule

// File: tb/tb_outport_fifo.sv
module tb_outport_fifo;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] bus_data;
  logic        outport_enable;
  logic        ovf_clr;
  logic        dev_ready;
  logic [31:0] dev_data;
  logic        dev_valid;
  logic [31:0] out_port_q;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        stall;

  int total = 0;
  int bad   = 0;

  // Scoreboard state: words the bench expects to be queued, in order.
  logic [31:0] m_q[$];
  logic        m_ovf;
  logic [31:0] m_outq;

  typedef struct {
    logic        en;
    logic [31:0] dat;
    logic        rdy;
    logic        oclr;
    logic [2:0]  exp_count;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[23];

  outport_fifo dut (
    .clk            (clk),
    .clr            (clr),
    .bus_data       (bus_data),
    .outport_enable (outport_enable),
    .ovf_clr        (ovf_clr),
    .dev_ready      (dev_ready),
    .dev_data       (dev_data),
    .dev_valid      (dev_valid),
    .out_port_q     (out_port_q),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  // One clock of stimulus: check the combinational head before the edge,
  // update the scoreboard, then check registered state after the edge.
  task automatic step(input logic en, input logic [31:0] d, input logic rdy, input logic oc);
    logic m_pop;
    logic m_push;
    logic m_full;
    @(negedge clk);
    outport_enable = en;
    bus_data       = d;
    dev_ready      = rdy;
    ovf_clr        = oc;
    #1;
    m_full = (m_q.size() == 4);
    chk("dev_valid", {31'd0, dev_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) chk("dev_data", dev_data, m_q[0]);
    chk("stall", {31'd0, stall}, {31'd0, m_full && !rdy});
    m_pop  = rdy && (m_q.size() != 0);
    m_push = en && (!m_full || m_pop);
    if (m_pop) m_outq = m_q.pop_front();
    if (m_push) m_q.push_back(d);
    if (en && m_full && !m_pop) m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("count", {29'd0, count}, m_q.size());
    chk("full", {31'd0, full}, {31'd0, m_q.size() == 4});
    chk("empty", {31'd0, empty}, {31'd0, m_q.size() == 0});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("out_port_q", out_port_q, m_outq);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 3'd1, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 32'h1,        1'b0, 1'b0, 3'd1, 1'b0};
    tbl[3]  = '{1'b1, 32'h2,        1'b0, 1'b0, 3'd2, 1'b0};
    tbl[4]  = '{1'b1, 32'h3,        1'b0, 1'b0, 3'd3, 1'b0};
    tbl[5]  = '{1'b1, 32'h4,        1'b0, 1'b0, 3'd4, 1'b0};
    tbl[6]  = '{1'b1, 32'h5,        1'b0, 1'b0, 3'd4, 1'b1};
    tbl[7]  = '{1'b1, 32'h6,        1'b0, 1'b1, 3'd4, 1'b1};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 3'd4, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 3'd3, 1'b0};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 3'd2, 1'b0};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 3'd1, 1'b0};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 3'd0, 1'b0};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 3'd0, 1'b0};
    tbl[14] = '{1'b1, 32'hA,        1'b0, 1'b0, 3'd1, 1'b0};
    tbl[15] = '{1'b1, 32'hB,        1'b0, 1'b0, 3'd2, 1'b0};
    tbl[16] = '{1'b1, 32'hC,        1'b0, 1'b0, 3'd3, 1'b0};
    tbl[17] = '{1'b1, 32'hD,        1'b0, 1'b0, 3'd4, 1'b0};
    tbl[18] = '{1'b1, 32'hE,        1'b1, 1'b0, 3'd4, 1'b0};
    tbl[19] = '{1'b0, 32'h0,        1'b1, 1'b0, 3'd3, 1'b0};
    tbl[20] = '{1'b0, 32'h0,        1'b1, 1'b0, 3'd2, 1'b0};
    tbl[21] = '{1'b0, 32'h0,        1'b1, 1'b0, 3'd1, 1'b0};
    tbl[22] = '{1'b0, 32'h0,        1'b1, 1'b0, 3'd0, 1'b0};

    clr            = 1'b0;
    bus_data       = '0;
    outport_enable = 1'b0;
    ovf_clr        = 1'b0;
    dev_ready      = 1'b0;
    m_ovf          = 1'b0;
    m_outq         = '0;

    // Reset state.
    #2;
    chk("rst_valid", {31'd0, dev_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_outq", out_port_q, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // Single word, fill/overflow/drain, and full-with-simultaneous-pop.
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].en, tbl[i].dat, tbl[i].rdy, tbl[i].oclr);
      chk($sformatf("tbl%0d_count", i), {29'd0, count}, {29'd0, tbl[i].exp_count});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, overflow}, {31'd0, tbl[i].exp_ovf});
    end
    chk("last_delivered", out_port_q, 32'hE);

    // Wrap-around: push and pop every cycle, occupancy stays at most 1.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h100 + i, 1'b1, 1'b0);
      chk("wrap_cnt_le1", {31'd0, count <= 3'd1}, 32'd1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap_last", out_port_q, 32'h109);

    // Asynchronous reset between edges with three words queued.
    step(1'b1, 32'h21, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'h23, 1'b0, 1'b0);
    outport_enable = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    chk("arst_valid", {31'd0, dev_valid}, 32'd0);
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_outq", out_port_q, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    m_q.delete();
    m_outq = '0;
    m_ovf  = 1'b0;
    @(negedge clk);
    clr = 1'b1;

    // First push after reset release lands on the next edge.
    step(1'b1, 32'h77, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("post_rst_word", out_port_q, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
